booth_iter_mul: RTL and testbench
=================================

# booth_iter_mul

Iterative radix-4 Booth multiplier for the M-extension execute path; it is the consumer stage of the `booth` partial-product selector. Each cycle it forms one 3-bit multiplier window and drives `booth`. It sign-extends and accumulates the returned partial product plus negate carry into a 2·WIDTH-bit running sum. After WIDTH/2+1 iterations it presents the low or high half as the MUL/MULH/MULHSU/MULHU result over a valid/ready handshake.

## Interface
- `WIDTH`, 32, operand width; must be even.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: block idle, can accept.
- `in_a` in WIDTH: multiplicand (rs1).
- `in_b` in WIDTH: multiplier (rs2).
- `in_op` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `flush` in 1: abort any in-flight operation.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts result.
- `out_result` out WIDTH: product half.
- `busy` out 1: high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE. `in_ready` = (state==IDLE).
- Accept (IDLE & `in_valid` & `in_ready` & ~`flush`):
  - Latch `in_op`.
  - a_ext (WIDTH+3 bits): sign-extended for MUL/MULH/MULHSU, zero-extended for MULHU.
  - b_ext (WIDTH+2 bits): sign-extended for MUL/MULH, zero-extended for MULHSU/MULHU.
  - Clear acc (2·WIDTH) and counter i. Go to BUSY.
- BUSY iteration i (0..WIDTH/2):
  - Window = {b_ext[2i+1], b_ext[2i], b_ext[2i−1]}, with b_ext[−1]=0.
  - `booth` (WIDTH = WIDTH+3) gets x=a_ext, s=window.
  - term = sext(p[WIDTH+2:0]) + c. The top p bit is ignored; the 2-bit headroom in a_ext makes ±x and ±2x exact.
  - acc ← (acc + (term << 2i)) mod 2^(2·WIDTH). i ← i+1.
  - After i = WIDTH/2, go to DONE.
- DONE:
  - `out_valid`=1. `out_result` = acc[WIDTH−1:0] for MUL, else acc[2·WIDTH−1:WIDTH].
  - Result is registered and held stable until `out_ready`. On `out_valid & out_ready`, go to IDLE.
- `flush` has priority in every state:
  - Next state is IDLE; `out_valid` drops next cycle; acc is discarded.
  - A same-cycle `in_valid` in IDLE is not accepted.
- `rst` overrides `flush`. Asserting it mid-operation discards all state.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_result` 0, `busy` 0, acc 0, i 0. `in_ready` is 1 from the first cycle after reset deasserts.
- Accept at edge T. Iterations occupy cycles T+1..T+WIDTH/2+1 (17 for WIDTH=32). `out_valid` is first high in cycle T+WIDTH/2+2: 18-cycle latency.
- `in_ready` is low from T+1 until the cycle after the output handshake. No overlap between operations.
- Best throughput is one operation per WIDTH/2+3 cycles (19 for WIDTH=32) with `out_ready` tied high.
- `out_result` is unchanged in BUSY and IDLE until the next DONE. It is only meaningful while `out_valid`.

## Structure
- Shared package `mul_pkg` holds:
  - op encodings (MUL/MULH/MULHSU/MULHU);
  - state enum;
  - ITER = WIDTH/2+1;
  - BW = WIDTH+3 (booth width).
- One sub-module: `booth` instance `u_booth` (WIDTH = BW).
- Everything else (window mux, term extension, shifter, accumulator, counter, FSM) lives in this module.

## Test plan
- MUL, a=7, b=0xFFFFFFFD → `out_result`=0xFFFFFFEB. `out_valid` first high exactly 18 cycles after accept.
- MULH, a=b=0x80000000 → 0x40000000. MULH, a=0xFFFFFFFF, b=0x00000002 → 0xFFFFFFFF.
- MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MUL, same operands → 0x00000001.
- MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MULHSU, a=0x00000002, b=0x80000000 → 0x00000001.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. Expect `out_valid`, `out_result` stable, `in_ready`=0. Assert `out_ready` → IDLE next cycle, `in_ready`=1.
- Flush/reset: `flush` in iteration 8 → IDLE next cycle, no `out_valid` ever. A new MUL 3×5 accepted afterwards yields 0x0000000F. Repeat with `rst` mid-BUSY → all outputs at reset values.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative Booth multiplier: op codes, FSM states, sizing.
package mul_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned ITER      = WIDTH_DEF / 2 + 1;
  localparam int unsigned BW        = WIDTH_DEF + 3;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Number of radix-4 iterations needed for a w-bit operand pair (includes sign window).
  function automatic int unsigned iter_cnt(input int unsigned w);
    return w / 2 + 1;
  endfunction

  // Partial-product selector width: two bits of headroom above a sign/zero-extended operand.
  function automatic int unsigned booth_w(input int unsigned w);
    return w + 3;
  endfunction

endpackage

// File: rtl/booth_iter_mul_booth.sv
// Radix-4 Booth partial-product selector: picks 0/±x/±2x, negation as one's complement + carry.
module booth #(
  parameter int unsigned WIDTH = 35
) (
  input  logic [WIDTH-1:0] x,
  input  logic [2:0]       s,
  output logic [WIDTH:0]   p,
  output logic             c
);

  logic [WIDTH:0] mag;
  logic           neg;

  // Decode the 3-bit window into a magnitude and a negate flag.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (s)
      3'b001, 3'b010: mag = {x[WIDTH-1], x};
      3'b011:         mag = {x, 1'b0};
      3'b100: begin
        mag = {x, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = {x[WIDTH-1], x};
        neg = 1'b1;
      end
      default: ;
    endcase
    p = neg ? ~mag : mag;
    c = neg;
  end

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU with valid/ready handshake.
module booth_iter_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int unsigned BW_L = booth_w(WIDTH);
  localparam int unsigned IT   = iter_cnt(WIDTH);
  localparam int unsigned IW   = $clog2(IT);
  localparam int unsigned AW   = 2 * WIDTH;

  state_e          state, state_nx;
  logic            accept_c;
  mul_op_e         op_q;
  logic [BW_L-1:0] a_ext;
  logic [WIDTH+1:0] b_sh;
  logic            b_prev;
  logic [IW-1:0]   i_q;
  logic [AW-1:0]   acc, acc_nx, term;
  logic [BW_L:0]   pp;
  logic            pp_neg;
  logic            pp_top_unused;
  logic            sign_a, sign_b;

  booth #(.WIDTH(BW_L)) u_booth (
    .x (a_ext),
    .s ({b_sh[1], b_sh[0], b_prev}),
    .p (pp),
    .c (pp_neg)
  );

  // Top selector bit is redundant thanks to the headroom in a_ext.
  assign pp_top_unused = pp[BW_L];

  assign sign_a = (in_op != 2'(OP_MULHU));
  assign sign_b = (in_op == 2'(OP_MUL)) || (in_op == 2'(OP_MULH));

  // Sign-extend the partial product, add the negate carry, align to this iteration.
  always_comb begin
    term   = {{(AW-BW_L){pp[BW_L-1]}}, pp[BW_L-1:0]} + AW'(pp_neg);
    acc_nx = acc + (term << {i_q, 1'b0});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; flush wins over every other transition.
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && !flush) begin
          state_nx = S_BUSY;
          accept_c = 1'b1;
        end
      end
      S_BUSY: begin
        if (flush)                          state_nx = S_IDLE;
        else if (i_q == IW'(IT - 1))        state_nx = S_DONE;
      end
      S_DONE: begin
        if (flush || out_ready)             state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath, result capture and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_MUL;
      a_ext      <= '0;
      b_sh       <= '0;
      b_prev     <= 1'b0;
      i_q        <= '0;
      acc        <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      if (flush) begin
        acc <= '0;
        i_q <= '0;
      end else if (accept_c) begin
        op_q   <= mul_op_e'(in_op);
        a_ext  <= {{3{sign_a & in_a[WIDTH-1]}}, in_a};
        b_sh   <= {{2{sign_b & in_b[WIDTH-1]}}, in_b};
        b_prev <= 1'b0;
        i_q    <= '0;
        acc    <= '0;
      end else if (state == S_BUSY) begin
        acc    <= acc_nx;
        i_q    <= i_q + IW'(1);
        b_sh   <= {2'b00, b_sh[WIDTH+1:2]};
        b_prev <= b_sh[1];
      end
      if (state == S_BUSY && state_nx == S_DONE)
        out_result <= (op_q == OP_MUL) ? acc_nx[WIDTH-1:0] : acc_nx[AW-1:WIDTH];
      out_valid <= (state_nx == S_DONE);
      busy      <= (state_nx != S_IDLE);
      in_ready  <= (state_nx == S_IDLE);
    end
  end

endmodule

// File: tb/tb_booth_iter_mul.sv
// Self-checking bench for booth_iter_mul against an arithmetic product model.
module tb_booth_iter_mul;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;
  localparam int LAT = 18;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_result;
  logic [1:0]  in_op;

  int  n_cmp = 0;
  int  n_bad = 0;
  time t_acc;

  booth_iter_mul #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact product of the extended operands, then pick the requested half.
  function automatic logic [31:0] model_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa, sb, pr;
    sa = (op == MULHU) ? $signed({34'd0, a}) : $signed({{34{a[31]}}, a});
    sb = (op == MUL || op == MULH) ? $signed({{34{b[31]}}, b}) : $signed({34'd0, b});
    pr = sa * sb;
    return (op == MUL) ? pr[31:0] : pr[63:32];
  endfunction

  // Issue one operation from a negedge; stall out_ready for 'stall' cycles once valid.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output logic [31:0] res, output int lat, output bit to);
    int k;
    to = 1'b0; lat = 0; res = '0;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin to = 1'b1; in_valid = 1'b0; return; end
    @(posedge clk); t_acc = $time;
    @(negedge clk); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    if (!out_valid) begin to = 1'b1; return; end
    lat = k + 1;
    res = out_result;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_bad++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed;
    logic [1:0]  ops[8] = '{MUL, MULH, MULH, MULHU, MUL, MULHSU, MULHSU, MUL};
    logic [31:0] da[8]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h0};
    logic [31:0] db[8]  = '{32'hFFFFFFFD, 32'h80000000, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
    logic [31:0] dr[8]  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h0};
    logic [31:0] res;
    int lat;
    bit to;
    for (int n = 0; n < 8; n++) begin
      run_op(ops[n], da[n], db[n], 0, res, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL directed_timeout[%0d]: got timeout expected result", n); end
      else begin
        if (res !== dr[n]) begin n_bad++; $display("FAIL directed[%0d]: got %h expected %h", n, res, dr[n]); end
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", n, lat, LAT); end
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, res, exp;
    logic [1:0]  op;
    int lat;
    bit to;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h0; 1: a = 32'h1; 2: a = 32'hFFFFFFFF; 3: a = 32'h80000000; 4: a = 32'h7FFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0; 1: b = 32'h1; 2: b = 32'hFFFFFFFF; 3: b = 32'h80000000; 4: b = 32'h7FFFFFFF;
        default: b = $urandom;
      endcase
      exp = model_mul(op, a, b);
      run_op(op, a, b, $urandom_range(0, 3), res, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL random_timeout[%0d]: got timeout expected result", n); end
      else if (res !== exp) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h expected %h", n, op, a, b, res, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    int k;
    exp = model_mul(MULH, 32'h9ABCDEF0, 32'h13579BDF);
    in_op = MULH; in_a = 32'h9ABCDEF0; in_b = 32'h13579BDF; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
      n_cmp++; if (out_result !== exp) begin n_bad++; $display("FAIL bp_result[%0d]: got %h expected %h", c, out_result, exp); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    bit to;
    time t1;
    run_op(MULHU, 32'hDEADBEEF, 32'hCAFEF00D, 0, res, lat, to);
    t1 = t_acc;
    run_op(MUL, 32'h11111111, 32'h3, 0, res, lat, to);
    n_cmp++;
    if ((t_acc - t1) / 10 !== 19) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 19", (t_acc - t1) / 10); end
    n_cmp++;
    if (res !== 32'h33333333) begin n_bad++; $display("FAIL b2b_result: got %h expected 33333333", res); end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int lat;
    bit to, seen;
    in_op = MUL; in_a = 32'h12345; in_b = 32'h6789; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b expected 0", busy); end
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle_accept: got busy %b expected 0", busy); end
    seen = 1'b0;
    repeat (25) begin if (out_valid) seen = 1'b1; @(negedge clk); end
    out_ready = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_valid: got %b expected 0", seen); end
    run_op(MUL, 32'd3, 32'd5, 0, res, lat, to);
    n_cmp++; if (res !== 32'h0000000F) begin n_bad++; $display("FAIL flush_recover: got %h expected 0000000f", res); end
  endtask

  task automatic test_rst_mid;
    logic [31:0] res;
    int lat;
    bit to;
    in_op = MULHU; in_a = 32'hFFFF0000; in_b = 32'h0000FFFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_bad++; $display("FAIL rst_mid_result: got %h expected 0", out_result); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    run_op(MUL, 32'd3, 32'd5, 0, res, lat, to);
    n_cmp++; if (res !== 32'h0000000F) begin n_bad++; $display("FAIL rst_recover: got %h expected 0000000f", res); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = MUL;
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
